// File: rtl/axi_burst_reader.sv
// axi_burst_reader
//   Fetches num_beats consecutive DATA_W-wide words starting at base_addr over
//   an AXI read channel, issuing bursts that never cross a 4 KB boundary nor
//   exceed MAX_BURST beats. Returned data is buffered in a first-word-fall-
//   through FIFO and presented as a ready/valid stream with s_last on the
//   final beat of the transfer.
//
//   Ports
//     clk, rst              : clock, asynchronous active-high reset
//     start, base_addr,
//     num_beats             : one-cycle transfer request and its arguments
//     busy, done, err       : transfer status (done is a one-cycle pulse)
//     m_axi_ar*             : AXI read-address channel (master side)
//     m_axi_r*              : AXI read-data channel (master side)
//     s_data/valid/last/ready : output stream
//
//   Optional build macro AXI_BURST_READER_ERR_CHECK_EN enables the sticky
//   response / rlast error check; without it err is tied low.
module axi_burst_reader #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_beats,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [DATA_W-1:0] s_data,
    output logic              s_valid,
    output logic              s_last,
    input  logic              s_ready
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LOG2_B = $clog2(BYTES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CMP_W  = LEN_W + 14;  // wide enough for every operand of the length/credit compares

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t             state_r, state_next_s;
    logic [ADDR_W-1:0]  addr_r;          // address of the next burst to request
    logic [LEN_W-1:0]   remaining_r;     // beats not yet requested
    logic [LEN_W-1:0]   beats_left_r;    // beats not yet delivered on the stream
    logic [8:0]         len_r;           // length of the burst in flight
    logic               busy_r, done_r, arvalid_r;
    logic [ADDR_W-1:0]  araddr_r;
    logic [7:0]         arlen_r;
    logic               rready_s;

    logic [DATA_W-1:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]     count_r;

    logic [12:0]        to_bound_s;
    logic [CMP_W-1:0]   len_ext_s;
    logic [8:0]         burst_len_s;
    logic               free_ok_s, launch_s, ar_hs_s, push_s, pop_s, s_valid_s, s_last_s;
    logic               burst_end_s;
    logic               unused_s;

    // Burst sizing: smallest of remaining beats, MAX_BURST and beats left before the next 4 KB page.
    always_comb begin
        to_bound_s  = (13'd4096 - {1'b0, addr_r[11:0]}) >> LOG2_B;
        len_ext_s   = CMP_W'(remaining_r);
        len_ext_s   = (CMP_W'(MAX_BURST) < len_ext_s) ? CMP_W'(MAX_BURST) : len_ext_s;
        len_ext_s   = (CMP_W'(to_bound_s) < len_ext_s) ? CMP_W'(to_bound_s) : len_ext_s;
        burst_len_s = len_ext_s[8:0];
        // Only request a burst when the whole burst is guaranteed to fit in the FIFO.
        free_ok_s   = (CMP_W'(FIFO_DEPTH) - CMP_W'(count_r)) >= CMP_W'(burst_len_s);
    end

    assign launch_s  = (state_r == ST_ADDR) && !arvalid_r && free_ok_s;
    assign ar_hs_s   = arvalid_r && m_axi_arready;
    assign push_s    = m_axi_rvalid && rready_s;
    assign s_valid_s = (count_r != {(PTR_W+1){1'b0}});
    assign pop_s     = s_valid_s && s_ready;
    // The FIFO head is the final transfer beat exactly when one beat remains undelivered.
    assign s_last_s  = s_valid_s && (beats_left_r == LEN_W'(1'b1));

`ifdef AXI_BURST_READER_ERR_CHECK_EN
    logic [8:0] beat_cnt_r;
    logic       last_exp_s;
    logic       err_r;

    assign last_exp_s  = (beat_cnt_r == (len_r - 9'd1));
    // Burst ends on the expected count so a misbehaving rlast cannot stall the transfer.
    assign burst_end_s = push_s && last_exp_s;
    assign err         = err_r;
    assign unused_s    = ^{base_addr[LOG2_B-1:0], len_ext_s[CMP_W-1:9]};

    // Sticky error flag and per-burst beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r      <= 1'b0;
            beat_cnt_r <= 9'd0;
        end else begin
            if ((state_r == ST_IDLE) && start) begin
                err_r <= 1'b0;
            end else if (push_s && ((m_axi_rresp != 2'b00) || (m_axi_rlast != last_exp_s))) begin
                err_r <= 1'b1;
            end
            if (ar_hs_s) begin
                beat_cnt_r <= 9'd0;
            end else if (push_s) begin
                beat_cnt_r <= beat_cnt_r + 9'd1;
            end
        end
    end
`else
    assign burst_end_s = push_s && m_axi_rlast;
    assign err         = 1'b0;
    assign unused_s    = ^{m_axi_rresp, base_addr[LOG2_B-1:0], len_ext_s[CMP_W-1:9]};
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && (num_beats != {LEN_W{1'b0}})) state_next_s = ST_ADDR;
                else                                        state_next_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (ar_hs_s) state_next_s = ST_DATA;
                else         state_next_s = ST_ADDR;
            end
            ST_DATA: begin
                if (burst_end_s) state_next_s = (remaining_r != {LEN_W{1'b0}}) ? ST_ADDR : ST_FLUSH;
                else             state_next_s = ST_DATA;
            end
            ST_FLUSH: begin
                if (pop_s && s_last_s) state_next_s = ST_IDLE;
                else                   state_next_s = ST_FLUSH;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        rready_s = 1'b0;
        case (state_r)
            ST_DATA: rready_s = 1'b1;
            default: rready_s = 1'b0;
        endcase
    end

    // Transfer bookkeeping, AR channel registers and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r       <= {ADDR_W{1'b0}};
            remaining_r  <= {LEN_W{1'b0}};
            beats_left_r <= {LEN_W{1'b0}};
            len_r        <= 9'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            arvalid_r    <= 1'b0;
            araddr_r     <= {ADDR_W{1'b0}};
            arlen_r      <= 8'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (num_beats == {LEN_W{1'b0}}) begin
                            done_r <= 1'b1;
                        end else begin
                            busy_r       <= 1'b1;
                            addr_r       <= {base_addr[ADDR_W-1:LOG2_B], {LOG2_B{1'b0}}};
                            remaining_r  <= num_beats;
                            beats_left_r <= num_beats;
                        end
                    end
                end
                ST_ADDR: begin
                    if (launch_s) begin
                        arvalid_r <= 1'b1;
                        araddr_r  <= addr_r;
                        arlen_r   <= 8'(burst_len_s - 9'd1);
                        len_r     <= burst_len_s;
                    end else if (ar_hs_s) begin
                        arvalid_r   <= 1'b0;
                        addr_r      <= addr_r + (ADDR_W'(len_r) << LOG2_B);
                        remaining_r <= remaining_r - LEN_W'(len_r);
                    end
                end
                ST_FLUSH: begin
                    if (pop_s && s_last_s) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
            if (pop_s) begin
                beats_left_r <= beats_left_r - LEN_W'(1'b1);
            end
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= m_axi_rdata;
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arlen   = arlen_r;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_s;
    assign s_data        = mem_r[rd_ptr_r];
    assign s_valid       = s_valid_s;
    assign s_last        = s_last_s;

endmodule
